pattern_tx_10110: RTL
=====================

// Module: pattern_tx_10110
// PURPOSE
//  Serial pattern transmitter; the sending end of the 10110 detection path.
//  On request it shifts PATTERN out MSB-first, one bit per accepted bit_en strobe.
//  The pattern is repeated rep_count times, with GAP_LEN idle zero bits between repetitions.
//  Drives stimulus and loopback links that feed the serial sequence detectors.
// PARAMETERS
//  PAT_LEN  5         pattern length in bits (>=1)
//  PATTERN  5'b10110  pattern bits; bit [PAT_LEN-1] is sent first
//  GAP_LEN  2         idle bits between repetitions (0 = back-to-back)
//  CNT_W    8         width of rep_count / sent_count
// PORTS
//  clk         in   1      rising-edge clock
//  reset       in   1      asynchronous, active-low reset
//  start       in   1      request; sampled only in IDLE
//  rep_count   in   CNT_W  repetitions; sampled with start
//  bit_en      in   1      bit-rate strobe; current bit consumed on clk edge where high
//  abort       in   1      terminate transfer; effective in SEND/GAP only
//  out_data    out  1      serial data; 0 when not in SEND
//  out_valid   out  1      out_data carries a pattern bit (SEND only)
//  busy        out  1      high in SEND and GAP
//  done        out  1      one-cycle pulse at end of request (normal, abort, or zero count)
//  sent_count  out  CNT_W  completed repetitions of current/last request
//  state       out  2      IDLE=00 SEND=01 GAP=10 DONE=11
// BEHAVIOUR
//  - Reset (reset=0, async) values: state=IDLE, out_data=0, out_valid=0, busy=0, done=0,
//    sent_count=0, and the bit index, gap counter and reps-left counter all cleared.
//    Reset mid-transfer drops everything immediately, with no done pulse.
//  - All outputs are registered.
//  - IDLE:
//    - start=1, rep_count!=0: clear sent_count, load reps_left=rep_count, bit_idx=PAT_LEN-1.
//      Next cycle: state=SEND, out_valid=1, busy=1, out_data=PATTERN[PAT_LEN-1].
//    - start=1, rep_count==0: clear sent_count; next cycle is DONE (done=1, no data sent).
//  - SEND: out_data=PATTERN[bit_idx], held until bit_en=1.
//    - bit_en=1 with bit_idx>0: decrement bit_idx; next bit appears the following cycle.
//    - bit_en=1 with bit_idx==0 (last bit): sent_count+1, reps_left-1, then:
//      - reps_left was 1: go to DONE.
//      - else GAP_LEN>0: go to GAP, gap_cnt=GAP_LEN.
//      - else GAP_LEN==0: stay in SEND, bit_idx=PAT_LEN-1, no idle cycle between reps.
//  - GAP: out_data=0, out_valid=0, busy=1.
//    - Each bit_en decrements gap_cnt; when gap_cnt reaches 0, go to SEND with bit_idx=PAT_LEN-1.
//  - DONE: exactly one cycle with done=1, busy=0, out_valid=0; then IDLE. start is ignored here.
//  - abort=1 in SEND or GAP: next state is DONE, regardless of bit_en (abort has priority).
//    sent_count keeps only completed repetitions; a partial repetition is not counted.
//  - start while busy or in DONE: ignored; it has no effect on the transfer in progress.
//  - abort in IDLE: ignored. start+abort together in IDLE: start is accepted.
//  - sent_count holds after done until the next accepted start; it saturates at 2^CNT_W-1.
//  - Latency: first bit is valid 1 cycle after start.
//    With bit_en tied high, a request of N reps takes N*PAT_LEN+(N-1)*GAP_LEN cycles in
//    SEND/GAP, followed by 1 DONE cycle.
// TESTING
//  1. bit_en=1, start, rep_count=1 -> out_data 1,0,1,1,0 on cycles 1-5 with out_valid=1;
//     done=1 on cycle 6; sent_count=1.
//  2. rep_count=3, GAP_LEN=2, bit_en=1 -> stream 10110 00 10110 00 10110;
//     out_valid=0 on the gap bits; done once; sent_count=3.
//  3. bit_en high every 3rd cycle, rep_count=1 -> each bit held exactly 3 cycles;
//     done follows the 5th strobe.
//  4. rep_count=2, abort asserted on bit 3 of rep 2 -> DONE next cycle; out_valid drops;
//     sent_count=1.
//  5. rep_count=0 -> done pulse on cycle 1, out_valid never asserts;
//     start re-pulsed during SEND -> no effect on the stream.
//  6. reset=0 mid-SEND -> all outputs 0 asynchronously;
//     loopback into the 10110 detector with rep_count=4 -> 4 detections.

Source files
------------

// File: rtl/pattern_tx_10110.sv
// Purpose : serial transmitter that shifts PATTERN out MSB-first, rep_count times, with GAP_LEN idle bits between repetitions.
// Latency : first bit is valid one cycle after an accepted start; one bit is consumed per bit_en strobe; done pulses for one cycle at the end.
// Backpr. : bit_en is the consumer's pace; a bit is held on out_data until a strobe takes it, and abort ends a transfer at once.
//
// Ports:
//   clk, reset         rising-edge clock, asynchronous active-low reset
//   start, rep_count   request and repetition count (sampled only in IDLE)
//   bit_en             strobe that consumes the current bit (or gap bit)
//   abort              ends the transfer from SEND/GAP (ignored elsewhere)
//   out_data/out_valid serial data and its qualifier (SEND only)
//   busy, done         transfer in progress / one-cycle end-of-request pulse
//   sent_count         completed repetitions of the current/last request (saturating)
//   state              IDLE=00 SEND=01 GAP=10 DONE=11
module pattern_tx_10110 #(
    parameter int                 PAT_LEN = 5,
    parameter logic [PAT_LEN-1:0] PATTERN = 5'b10110,
    parameter int                 GAP_LEN = 2,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] rep_count,
    input  logic             bit_en,
    input  logic             abort,
    output logic             out_data,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sent_count,
    output logic [1:0]       state
);

    localparam int IW = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;
    localparam int GW = (GAP_LEN > 0) ? $clog2(GAP_LEN + 1) : 1;
    localparam logic [IW-1:0]    LAST_IDX = IW'(PAT_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_SEND = 2'b01,
        S_GAP  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t           cur_state, nxt_state;
    logic [IW-1:0]    bit_idx, bit_idx_nxt;
    logic [GW-1:0]    gap_cnt, gap_cnt_nxt;
    logic [CNT_W-1:0] reps_left, reps_left_nxt;
    logic [CNT_W-1:0] sent_nxt;
    logic             out_data_nxt, out_valid_nxt, busy_nxt, done_nxt;

    assign state = cur_state;

    always_comb begin
        nxt_state     = cur_state;
        bit_idx_nxt   = bit_idx;
        gap_cnt_nxt   = gap_cnt;
        reps_left_nxt = reps_left;
        sent_nxt      = sent_count;

        case (cur_state)
            S_IDLE: begin
                // abort is meaningless here, so start wins when both are high
                if (start) begin
                    sent_nxt = '0;
                    if (rep_count != '0) begin
                        reps_left_nxt = rep_count;
                        bit_idx_nxt   = LAST_IDX;
                        nxt_state     = S_SEND;
                    end else begin
                        nxt_state = S_DONE;
                    end
                end
            end
            S_SEND: begin
                if (abort) begin
                    // a partially sent repetition is not counted
                    nxt_state = S_DONE;
                end else if (bit_en) begin
                    if (bit_idx != '0) begin
                        bit_idx_nxt = bit_idx - IW'(1);
                    end else begin
                        if (sent_count != CNT_MAX) sent_nxt = sent_count + CNT_W'(1);
                        reps_left_nxt = reps_left - CNT_W'(1);
                        if (reps_left == CNT_W'(1)) begin
                            nxt_state = S_DONE;
                        end else if (GAP_LEN > 0) begin
                            nxt_state   = S_GAP;
                            gap_cnt_nxt = GW'(GAP_LEN);
                        end else begin
                            // back-to-back repetitions: wrap straight to the first bit
                            bit_idx_nxt = LAST_IDX;
                        end
                    end
                end
            end
            S_GAP: begin
                if (abort) begin
                    nxt_state = S_DONE;
                end else if (bit_en) begin
                    if (gap_cnt <= GW'(1)) begin
                        gap_cnt_nxt = '0;
                        bit_idx_nxt = LAST_IDX;
                        nxt_state   = S_SEND;
                    end else begin
                        gap_cnt_nxt = gap_cnt - GW'(1);
                    end
                end
            end
            S_DONE: begin
                nxt_state = S_IDLE;
            end
            default: begin
                nxt_state = S_IDLE;
            end
        endcase

        // outputs are computed from the next state so they can be registered
        // alongside it without adding a cycle of latency
        out_data_nxt  = (nxt_state == S_SEND) ? PATTERN[bit_idx_nxt] : 1'b0;
        out_valid_nxt = (nxt_state == S_SEND);
        busy_nxt      = (nxt_state == S_SEND) || (nxt_state == S_GAP);
        done_nxt      = (nxt_state == S_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_state  <= S_IDLE;
            bit_idx    <= '0;
            gap_cnt    <= '0;
            reps_left  <= '0;
            sent_count <= '0;
            out_data   <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            cur_state  <= nxt_state;
            bit_idx    <= bit_idx_nxt;
            gap_cnt    <= gap_cnt_nxt;
            reps_left  <= reps_left_nxt;
            sent_count <= sent_nxt;
            out_data   <= out_data_nxt;
            out_valid  <= out_valid_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
        end
    end

endmodule
